mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL expose these ports: clk  in  1  rising-edge clock.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 op  in  6  IR[31:26]; funct  in  6  IR[5:0].
REQ-004 zero  in  1  ALU equality flag; alu_overflow  in  1  ALU signed-overflow flag.
REQ-005 PCWr, IRWr, GPRWr, DMWr  out  1 each  write enables for PC, IR, register file, data memory.
REQ-006 npc_sel  out  2  next-PC select: 0=PC+4, 1=branch, 2=jump, 3=register (jr).
REQ-007 reg_dst  out  2  dest select: 0=rt, 1=rd, 2=$31; wd_sel  out  2  write-data select: 0=ALU, 1=memory, 2=PC+4.
REQ-008 alu_ctrl  out  3  0=add, 1=sub, 2=or, 3=lui, 4=slt; alu_src_b  out  1  0=register, 1=extended immediate; ext_op  out  2  0=zero, 1=sign, 2=upper.
REQ-009 slt_ctrl, ovf_set  out  1 each  slt write qualifier and $30[0] flag-set pulse.
REQ-010 instr_done  out  1  one-cycle pulse in the final state of each instruction; state  out  4  current state code.

Function
REQ-011 Supported instructions SHALL be addu, subu, slt, jr, ori, lui, addi, lw, sw, beq, j and jal; any other op/funct SHALL be treated as illegal.
REQ-012 States SHALL be FETCH, DECODE, EXE, ALUWB, BRANCH, MA, MR, MWB and MW, in one binary-encoded state register.
REQ-013 FETCH: PCWr=1, IRWr=1, npc_sel=0; next state is always DECODE.
REQ-014 DECODE for j: PCWr=1, npc_sel=2, instr_done=1; next state FETCH.
REQ-015 DECODE for jal: PCWr=1, npc_sel=2, GPRWr=1, reg_dst=2, wd_sel=2, instr_done=1; next state FETCH.
REQ-016 DECODE for jr: PCWr=1, npc_sel=3, instr_done=1; next state FETCH.
REQ-017 DECODE next state SHALL be BRANCH for beq, MA for lw/sw, and EXE for R-type, ori, lui and addi.
REQ-018 DECODE for an illegal instruction: instr_done=1, no write enables; next state FETCH.
REQ-019 EXE drives alu_ctrl, alu_src_b and ext_op for the instruction and goes to ALUWB.
REQ-020 ALUWB holds the EXE ALU controls and asserts GPRWr=1, wd_sel=0, reg_dst=1 for R-type and 0 otherwise, and instr_done=1; slt SHALL also assert slt_ctrl=1; next state FETCH.
REQ-021 BRANCH: alu_ctrl=1, PCWr=zero, npc_sel=1, instr_done=1; next state FETCH.
REQ-022 MA: alu_ctrl=0, alu_src_b=1, ext_op=1; next state MR for lw and MW for sw.
REQ-023 MR goes to MWB.
REQ-024 MWB: GPRWr=1, wd_sel=1, reg_dst=0, instr_done=1; next state FETCH.
REQ-025 MW: DMWr=1, instr_done=1; next state FETCH.
REQ-026 Latency in cycles SHALL be: j/jal/jr/illegal 2, beq 3, ALU-class 4, sw 4, lw 5.
REQ-027 Outputs SHALL be combinational from the state register and op/funct; op/funct are stable because IR changes only in FETCH.
REQ-028 Every output not named for a state SHALL be 0 in that state.

Reset
REQ-029 While rst=1 at a clock edge, state SHALL load FETCH.
REQ-030 While rst=1, every write enable, ovf_set and instr_done SHALL be forced to 0.
REQ-031 rst asserted mid-instruction SHALL abandon the instruction with no further writes; the first cycle after rst falls SHALL be FETCH.

Configuration
REQ-032 With OVF_TRAP_EN defined, an addi ALUWB cycle with alu_overflow=1 SHALL assert GPRWr=0 and ovf_set=1.
REQ-033 Without OVF_TRAP_EN, addi SHALL always write its result, and ovf_set SHALL be constant 0.

Structure
REQ-034 Package mc_pkg SHALL hold the state encoding, opcode/funct constants, and the npc_sel, wd_sel, reg_dst, alu_ctrl and ext_op codes.
REQ-035 Combinational sub-module mc_decode SHALL classify op/funct into the instruction class plus an illegal flag; mc_ctrl holds the FSM.

Verification
REQ-036 rst=1 for 2 cycles then addu (op=0x00, funct=0x21) -> states FETCH,DECODE,EXE,ALUWB; GPRWr=1 and reg_dst=1 only in cycle 4; instr_done pulses once.
REQ-037 lw (op=0x23) -> 5-cycle sequence ending in MWB with wd_sel=1; sw (op=0x2B) -> DMWr=1 only in MW; GPRWr never asserted.
REQ-038 beq (op=0x04) with zero=1 -> PCWr=1, npc_sel=1 in BRANCH; with zero=0 -> PCWr=0 and return to FETCH.
REQ-039 jal (op=0x03) -> DECODE asserts PCWr, GPRWr, reg_dst=2, wd_sel=2; op=0x3F -> illegal: 2 cycles with no writes.
REQ-040 addi (op=0x08) with alu_overflow=1 -> with OVF_TRAP_EN: GPRWr=0, ovf_set=1; without: GPRWr=1; rst in MR of lw -> next cycle FETCH, no GPRWr.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset controller.
//   - FSM state codes (binary, 4 bits, also driven on mc_ctrl.state)
//   - opcode / funct constants for the supported instructions
//   - instruction class codes produced by mc_decode
//   - mux select codes: npc_sel, reg_dst, wd_sel, alu_ctrl, ext_op
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_ALUWB  = 4'd3,
        S_BRANCH = 4'd4,
        S_MA     = 4'd5,
        S_MR     = 4'd6,
        S_MWB    = 4'd7,
        S_MW     = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        IC_ADDU = 4'd0,
        IC_SUBU = 4'd1,
        IC_SLT  = 4'd2,
        IC_JR   = 4'd3,
        IC_ORI  = 4'd4,
        IC_LUI  = 4'd5,
        IC_ADDI = 4'd6,
        IC_LW   = 4'd7,
        IC_SW   = 4'd8,
        IC_BEQ  = 4'd9,
        IC_J    = 4'd10,
        IC_JAL  = 4'd11,
        IC_ILL  = 4'd15
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JMP  = 2'd2;
    localparam logic [1:0] NPC_REG  = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_PC4   = 2'd2;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_UP   = 2'd2;

    // R-type ALU ops write rd; immediate ALU ops write rt
    function automatic logic is_rtype_alu(input iclass_t cls);
        return (cls == IC_ADDU) || (cls == IC_SUBU) || (cls == IC_SLT);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   op        in  6  IR[31:26]
//   funct     in  6  IR[5:0]
//   o_class   out 4  instruction class (iclass_t)
//   o_illegal out 1  op/funct not in the supported set
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    o_class,
    output logic       o_illegal
);

    always_comb begin
        o_class = IC_ILL;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: o_class = IC_ADDU;
                    FN_SUBU: o_class = IC_SUBU;
                    FN_SLT:  o_class = IC_SLT;
                    FN_JR:   o_class = IC_JR;
                    default: o_class = IC_ILL;
                endcase
            end
            OP_J:    o_class = IC_J;
            OP_JAL:  o_class = IC_JAL;
            OP_BEQ:  o_class = IC_BEQ;
            OP_ADDI: o_class = IC_ADDI;
            OP_ORI:  o_class = IC_ORI;
            OP_LUI:  o_class = IC_LUI;
            OP_LW:   o_class = IC_LW;
            OP_SW:   o_class = IC_SW;
            default: o_class = IC_ILL;
        endcase
    end

    assign o_illegal = (o_class == IC_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a MIPS subset
// (addu subu slt jr ori lui addi lw sw beq j jal).
// Ports:
//   clk, rst (sync, active-high)       op, funct, zero, alu_overflow in
//   PCWr IRWr GPRWr DMWr               write enables
//   npc_sel reg_dst wd_sel alu_ctrl alu_src_b ext_op   datapath selects
//   slt_ctrl ovf_set instr_done state  status
// Build option: define OVF_TRAP_EN to suppress the addi write on signed
// overflow and pulse ovf_set instead.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | jumps / illegal complete here, else dispatch
// EXE    | ALU operation for R-type / immediate ALU ops
// ALUWB  | write ALU result to register file
// BRANCH | beq compare, conditional PC update
// MA     | memory address computation
// MR     | memory read
// MWB    | write loaded data to register file
// MW     | memory write
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       alu_overflow,
    output logic       PCWr,
    output logic       IRWr,
    output logic       GPRWr,
    output logic       DMWr,
    output logic [1:0] npc_sel,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_b,
    output logic [1:0] ext_op,
    output logic       slt_ctrl,
    output logic       ovf_set,
    output logic       instr_done,
    output logic [3:0] state
);

    state_t  r_state;
    state_t  w_next;
    iclass_t w_class;
    logic    w_illegal;

`ifndef OVF_TRAP_EN
    logic    w_unused_ovf;
    assign w_unused_ovf = alu_overflow;
`endif

    mc_decode u_decode (
        .op        (op),
        .funct     (funct),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next     = S_FETCH;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        GPRWr      = 1'b0;
        DMWr       = 1'b0;
        npc_sel    = NPC_PC4;
        reg_dst    = RD_RT;
        wd_sel     = WD_ALU;
        alu_ctrl   = ALU_ADD;
        alu_src_b  = 1'b0;
        ext_op     = EXT_ZERO;
        slt_ctrl   = 1'b0;
        ovf_set    = 1'b0;
        instr_done = 1'b0;

        // EXE and ALUWB share the same ALU setup so the result stays stable
        // while it is written back.
        if (r_state == S_EXE || r_state == S_ALUWB) begin
            unique case (w_class)
                IC_SUBU: alu_ctrl = ALU_SUB;
                IC_SLT:  alu_ctrl = ALU_SLT;
                IC_ORI:  begin alu_ctrl = ALU_OR;  alu_src_b = 1'b1; ext_op = EXT_ZERO; end
                IC_LUI:  begin alu_ctrl = ALU_LUI; alu_src_b = 1'b1; ext_op = EXT_UP;   end
                IC_ADDI: begin alu_ctrl = ALU_ADD; alu_src_b = 1'b1; ext_op = EXT_SIGN; end
                default: alu_ctrl = ALU_ADD;
            endcase
        end

        unique case (r_state)
            S_FETCH: begin
                PCWr   = 1'b1;
                IRWr   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_illegal) begin
                    instr_done = 1'b1;
                end else begin
                    unique case (w_class)
                        IC_J: begin
                            PCWr = 1'b1; npc_sel = NPC_JMP; instr_done = 1'b1;
                        end
                        IC_JAL: begin
                            PCWr = 1'b1; npc_sel = NPC_JMP; GPRWr = 1'b1;
                            reg_dst = RD_RA; wd_sel = WD_PC4; instr_done = 1'b1;
                        end
                        IC_JR: begin
                            PCWr = 1'b1; npc_sel = NPC_REG; instr_done = 1'b1;
                        end
                        IC_BEQ:         w_next = S_BRANCH;
                        IC_LW, IC_SW:   w_next = S_MA;
                        default:        w_next = S_EXE;
                    endcase
                end
            end
            S_EXE: w_next = S_ALUWB;
            S_ALUWB: begin
                wd_sel     = WD_ALU;
                reg_dst    = is_rtype_alu(w_class) ? RD_RD : RD_RT;
                slt_ctrl   = (w_class == IC_SLT);
                instr_done = 1'b1;
`ifdef OVF_TRAP_EN
                if (w_class == IC_ADDI && alu_overflow) begin
                    GPRWr   = 1'b0;
                    ovf_set = 1'b1;
                end else begin
                    GPRWr   = 1'b1;
                end
`else
                GPRWr      = 1'b1;
`endif
            end
            S_BRANCH: begin
                alu_ctrl   = ALU_SUB;
                PCWr       = zero;
                npc_sel    = NPC_BR;
                instr_done = 1'b1;
            end
            S_MA: begin
                alu_ctrl  = ALU_ADD;
                alu_src_b = 1'b1;
                ext_op    = EXT_SIGN;
                w_next    = (w_class == IC_SW) ? S_MW : S_MR;
            end
            S_MR: w_next = S_MWB;
            S_MWB: begin
                GPRWr      = 1'b1;
                wd_sel     = WD_MEM;
                reg_dst    = RD_RT;
                instr_done = 1'b1;
            end
            S_MW: begin
                DMWr       = 1'b1;
                instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset abandons whatever is in flight: no architectural writes.
        if (rst) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            GPRWr      = 1'b0;
            DMWr       = 1'b0;
            ovf_set    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, alu_overflow;
    logic       PCWr, IRWr, GPRWr, DMWr;
    logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_ctrl;
    logic       alu_src_b, slt_ctrl, ovf_set, instr_done;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .alu_overflow(alu_overflow), .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr),
        .DMWr(DMWr), .npc_sel(npc_sel), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .slt_ctrl(slt_ctrl), .ovf_set(ovf_set), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] vec;
        string       tag;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [22:0] act;
    int          n_tests = 0;
    int          n_fail  = 0;

    // {state, PCWr, IRWr, GPRWr, DMWr, npc_sel, reg_dst, wd_sel,
    //  alu_ctrl, alu_src_b, ext_op, slt_ctrl, ovf_set, instr_done}
    function automatic logic [22:0] v(input logic [3:0] st,
                                      input logic pc, input logic ir,
                                      input logic gpr, input logic dm,
                                      input logic [1:0] npc, input logic [1:0] rd,
                                      input logic [1:0] wd, input logic [2:0] alu,
                                      input logic srcb, input logic [1:0] ext,
                                      input logic slt, input logic ovf,
                                      input logic done);
        return {st, pc, ir, gpr, dm, npc, rd, wd, alu, srcb, ext, slt, ovf, done};
    endfunction

    task automatic push(input string tag, input logic [22:0] vec);
        exp_t e;
        e.vec = vec;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f,
                          input logic z, input logic ov);
        op = o; funct = f; zero = z; alu_overflow = ov;
    endtask

    // monitor: the DUT presents one control word per cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            act = {state, PCWr, IRWr, GPRWr, DMWr, npc_sel, reg_dst, wd_sel,
                   alu_ctrl, alu_src_b, ext_op, slt_ctrl, ovf_set, instr_done};
            n_tests++;
            if (act !== cur.vec) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", cur.tag, act, cur.vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [22:0] F, D0;

    initial begin
        F  = v(S_FETCH, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0);
        D0 = v(S_DECODE,0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
        rst = 1'b1;
        set_in(6'h00, 6'h21, 1'b0, 1'b0);

        // reset: two edges with rst high, enables forced low
        @(posedge clk); #1;
        push("rst.c1", v(S_FETCH,0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        tick(1);
        rst = 1'b0;

        // addu
        push("addu.F", F); push("addu.D", D0);
        push("addu.E", v(S_EXE,  0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        push("addu.W", v(S_ALUWB,0,0,1,0, 0,1,0, 0,0,0, 0,0,1));
        tick(4);

        // subu
        set_in(6'h00, 6'h23, 1'b0, 1'b0);
        push("subu.F", F); push("subu.D", D0);
        push("subu.E", v(S_EXE,  0,0,0,0, 0,0,0, 1,0,0, 0,0,0));
        push("subu.W", v(S_ALUWB,0,0,1,0, 0,1,0, 1,0,0, 0,0,1));
        tick(4);

        // slt
        set_in(6'h00, 6'h2A, 1'b0, 1'b0);
        push("slt.F", F); push("slt.D", D0);
        push("slt.E", v(S_EXE,  0,0,0,0, 0,0,0, 4,0,0, 0,0,0));
        push("slt.W", v(S_ALUWB,0,0,1,0, 0,1,0, 4,0,0, 1,0,1));
        tick(4);

        // ori
        set_in(6'h0D, 6'h3F, 1'b0, 1'b0);
        push("ori.F", F); push("ori.D", D0);
        push("ori.E", v(S_EXE,  0,0,0,0, 0,0,0, 2,1,0, 0,0,0));
        push("ori.W", v(S_ALUWB,0,0,1,0, 0,0,0, 2,1,0, 0,0,1));
        tick(4);

        // lui
        set_in(6'h0F, 6'h00, 1'b0, 1'b0);
        push("lui.F", F); push("lui.D", D0);
        push("lui.E", v(S_EXE,  0,0,0,0, 0,0,0, 3,1,2, 0,0,0));
        push("lui.W", v(S_ALUWB,0,0,1,0, 0,0,0, 3,1,2, 0,0,1));
        tick(4);

        // addi, no overflow
        set_in(6'h08, 6'h00, 1'b0, 1'b0);
        push("addi.F", F); push("addi.D", D0);
        push("addi.E", v(S_EXE,  0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
        push("addi.W", v(S_ALUWB,0,0,1,0, 0,0,0, 0,1,1, 0,0,1));
        tick(4);

        // addi with overflow
        set_in(6'h08, 6'h00, 1'b0, 1'b1);
        push("addiov.F", F); push("addiov.D", D0);
        push("addiov.E", v(S_EXE, 0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
`ifdef OVF_TRAP_EN
        push("addiov.W", v(S_ALUWB,0,0,0,0, 0,0,0, 0,1,1, 0,1,1));
`else
        push("addiov.W", v(S_ALUWB,0,0,1,0, 0,0,0, 0,1,1, 0,0,1));
`endif
        tick(4);

        // lw
        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        push("lw.F", F); push("lw.D", D0);
        push("lw.MA",  v(S_MA, 0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
        push("lw.MR",  v(S_MR, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        push("lw.MWB", v(S_MWB,0,0,1,0, 0,0,1, 0,0,0, 0,0,1));
        tick(5);

        // sw
        set_in(6'h2B, 6'h00, 1'b0, 1'b0);
        push("sw.F", F); push("sw.D", D0);
        push("sw.MA", v(S_MA,0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
        push("sw.MW", v(S_MW,0,0,0,1, 0,0,0, 0,0,0, 0,0,1));
        tick(4);

        // beq taken / not taken
        set_in(6'h04, 6'h00, 1'b1, 1'b0);
        push("beq1.F", F); push("beq1.D", D0);
        push("beq1.B", v(S_BRANCH,1,0,0,0, 1,0,0, 1,0,0, 0,0,1));
        tick(3);
        set_in(6'h04, 6'h00, 1'b0, 1'b0);
        push("beq0.F", F); push("beq0.D", D0);
        push("beq0.B", v(S_BRANCH,0,0,0,0, 1,0,0, 1,0,0, 0,0,1));
        tick(3);

        // j, jal, jr
        set_in(6'h02, 6'h00, 1'b0, 1'b0);
        push("j.F", F);
        push("j.D", v(S_DECODE,1,0,0,0, 2,0,0, 0,0,0, 0,0,1));
        tick(2);
        set_in(6'h03, 6'h00, 1'b0, 1'b0);
        push("jal.F", F);
        push("jal.D", v(S_DECODE,1,0,1,0, 2,2,2, 0,0,0, 0,0,1));
        tick(2);
        set_in(6'h00, 6'h08, 1'b0, 1'b0);
        push("jr.F", F);
        push("jr.D", v(S_DECODE,1,0,0,0, 3,0,0, 0,0,0, 0,0,1));
        tick(2);

        // illegal opcode and illegal R-type funct
        set_in(6'h3F, 6'h00, 1'b0, 1'b0);
        push("ill.F", F);
        push("ill.D", v(S_DECODE,0,0,0,0, 0,0,0, 0,0,0, 0,0,1));
        tick(2);
        set_in(6'h00, 6'h3F, 1'b0, 1'b0);
        push("illr.F", F);
        push("illr.D", v(S_DECODE,0,0,0,0, 0,0,0, 0,0,0, 0,0,1));
        tick(2);

        // rst during MR of lw: abandoned, next cycle FETCH
        set_in(6'h23, 6'h00, 1'b0, 1'b0);
        push("lwrst.F", F); push("lwrst.D", D0);
        push("lwrst.MA", v(S_MA,0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
        tick(3);
        rst = 1'b1;
        push("lwrst.MR", v(S_MR,0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        tick(1);
        rst = 1'b0;

        // rst during ALUWB of addu: writes and done forced low
        set_in(6'h00, 6'h21, 1'b0, 1'b0);
        push("aurst.F", F); push("aurst.D", D0);
        push("aurst.E", v(S_EXE,0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        tick(3);
        rst = 1'b1;
        push("aurst.W", v(S_ALUWB,0,0,0,0, 0,1,0, 0,0,0, 0,0,0));
        tick(1);
        rst = 1'b0;

        // after reset the FSM restarts cleanly with sw
        set_in(6'h2B, 6'h00, 1'b0, 1'b0);
        push("post.F", F); push("post.D", D0);
        push("post.MA", v(S_MA,0,0,0,0, 0,0,0, 0,1,1, 0,0,0));
        push("post.MW", v(S_MW,0,0,0,1, 0,0,0, 0,0,0, 0,0,1));
        tick(4);

        tick(2);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
